instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming MIPS instruction encoder: the inverse of the control decoder. It accepts one mnemonic plus operand fields per handshake and emits the matching 32-bit instruction word, tagged with its sequential byte address, on an output handshake. It sits in the program-loader path ahead of instruction memory. The supported set is exactly the one the core decodes: addu, subu, ori, lui, lw, sw, beq, jr, jal, bgez, bgtz, blez, bltz, bne, slt, slti, sltiu, sltu.

## Interface
- ADDR_W, 10: word-index width; DEPTH = 2^ADDR_W words.
- BASE_ADDR, 32'h0000_3000: byte address of word 0.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- clear  in  1  synchronous restart; same effect as reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- op  in  5  mnemonic: 0 addu, 1 subu, 2 ori, 3 lui, 4 lw, 5 sw, 6 beq, 7 jr, 8 jal, 9 bgez, 10 bgtz, 11 blez, 12 bltz, 13 bne, 14 slt, 15 slti, 16 sltiu, 17 sltu; 18–31 illegal.
- rs, rt, rd  in  5 each  register fields.
- imm  in  16  immediate / branch offset.
- target  in  26  jal target field.
- out_valid  out  1  out_instr/out_addr valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_instr  out  32  encoded word.
- out_addr  out  32  BASE_ADDR + 4*index.
- count  out  ADDR_W+1  words emitted since reset/clear.
- full  out  1  count == DEPTH.
- illegal  out  1  sticky; an illegal op was consumed.

## Operation
- R-type ops emit {6'b0, rs, rt, rd, 5'b0, func}. The func codes are addu 100001, subu 100011, slt 101010, sltu 101011, jr 001000.
- For jr, rt and rd are forced to 0.
- I-type ops emit {opc, rs, rt, imm}. The opcodes are ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, bne 000101, slti 001010, sltiu 001011.
- For lui, rs is forced to 0.
- bgtz uses opcode 000111 and blez uses 000110; for both, the rt field is forced to 0.
- bgez emits {000001, rs, 00001, imm}. bltz emits {000001, rs, 00000, imm}.
- jal emits {000011, target}.
- Fields an op does not use are ignored, never passed through.
- Output stage is a single register holding out_instr, out_addr and out_valid. Acceptance rule:
  - in_ready = (!out_valid || out_ready) && (count + out_valid < DEPTH). It depends combinationally on out_ready.
- A legal accepted request loads the output register and sets out_valid.
- An illegal accepted request is consumed but does not load the register or advance the index; it sets `illegal`. If out_ready drains the current word in the same cycle, out_valid falls.
- Output handshake: count increments by 1. out_addr of the next word = BASE_ADDR + 4*(count at load time, including any in-flight word).
- Simultaneous output handshake and legal accept: the old word retires, the new word loads, and out_valid stays 1.
- When full = 1, in_ready = 0 permanently until reset/clear. Count saturates and never wraps.
- clear has priority over any handshake in the same cycle; that word is discarded.
- Reset/clear values: out_valid 0, out_instr 0, out_addr BASE_ADDR, count 0, full 0, illegal 0. in_ready is 1 after the edge.

## Timing
- Latency: a request accepted at edge N is presented with out_valid = 1 from N+1.
- Throughput is 1 word/cycle while out_ready is held high.
- out_instr and out_addr are stable while out_valid && !out_ready. in_ready = 0 in that state.
- Reset or clear asserted mid-stream takes effect at the next edge. No partial word survives.

## Test plan
- Reset, then addu rs=1 rt=2 rd=3 with out_ready=1 -> next cycle out_instr 0x00221821, out_addr 0x00003000, then count=1.
- Back-to-back lui rt=1 imm=0x1234; jr rs=31 rt=7 rd=9; jal target=0x0000C00; sw rs=0 rt=8 imm=4 -> 0x3C011234, 0x03E00008, 0x0C000C00, 0xAC080004 at addresses 0x3000/3004/3008/300C, one per cycle.
- bgez rs=5 imm=0xFFFF then bltz rs=5 imm=0xFFFF -> 0x04A1FFFF, 0x04A0FFFF.
- Backpressure: hold out_ready=0 for 3 cycles with a word held -> out_* unchanged and in_ready=0; on release, the word retires and the next word loads in the same cycle.
- Illegal op 25 between two addu requests -> illegal=1, only 2 words emitted, with addresses contiguous at 0x3000/0x3004.
- ADDR_W=2: stream 6 requests -> exactly 4 emitted, full=1, in_ready=0. Then clear -> count=0 and out_addr=0x3000; a clear coincident with an output handshake discards that word.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request/response bundle for the instruction encoder: one request handshake in,
// one encoded-word handshake out.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;

    modport master (
        output in_valid, op, rs, rt, rd, imm, target, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, op, rs, rt, rd, imm, target, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/instr_encoder.sv
// Streaming MIPS encoder: turns mnemonic + operand fields into 32-bit words
// tagged with sequential byte addresses, through a single output register.
module instr_encoder #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    instr_encoder_if.slave    bus,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              illegal
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);

    typedef enum logic [4:0] {
        OP_ADDU  = 5'd0,  OP_SUBU  = 5'd1,  OP_ORI   = 5'd2,  OP_LUI   = 5'd3,
        OP_LW    = 5'd4,  OP_SW    = 5'd5,  OP_BEQ   = 5'd6,  OP_JR    = 5'd7,
        OP_JAL   = 5'd8,  OP_BGEZ  = 5'd9,  OP_BGTZ  = 5'd10, OP_BLEZ  = 5'd11,
        OP_BLTZ  = 5'd12, OP_BNE   = 5'd13, OP_SLT   = 5'd14, OP_SLTI  = 5'd15,
        OP_SLTIU = 5'd16, OP_SLTU  = 5'd17
    } op_e;

    logic [ADDR_W:0]   count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [31:0]       out_addr_q, out_addr_d;
    logic              illegal_q, illegal_d;

    logic [31:0]       enc;
    logic              legal;
    logic [ADDR_W+1:0] occupancy;
    logic              accept, retire, load;

    always_comb begin
        legal = 1'b1;
        enc   = '0;
        case (op_e'(bus.op))
            OP_ADDU:  enc = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b100001};
            OP_SUBU:  enc = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b100011};
            OP_SLT:   enc = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b101010};
            OP_SLTU:  enc = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b101011};
            OP_JR:    enc = {6'b000000, bus.rs, 5'b0, 5'b0, 5'b0, 6'b001000};
            OP_ORI:   enc = {6'b001101, bus.rs, bus.rt, bus.imm};
            OP_LUI:   enc = {6'b001111, 5'b0, bus.rt, bus.imm};
            OP_LW:    enc = {6'b100011, bus.rs, bus.rt, bus.imm};
            OP_SW:    enc = {6'b101011, bus.rs, bus.rt, bus.imm};
            OP_BEQ:   enc = {6'b000100, bus.rs, bus.rt, bus.imm};
            OP_BNE:   enc = {6'b000101, bus.rs, bus.rt, bus.imm};
            OP_SLTI:  enc = {6'b001010, bus.rs, bus.rt, bus.imm};
            OP_SLTIU: enc = {6'b001011, bus.rs, bus.rt, bus.imm};
            OP_BGTZ:  enc = {6'b000111, bus.rs, 5'b0, bus.imm};
            OP_BLEZ:  enc = {6'b000110, bus.rs, 5'b0, bus.imm};
            OP_BGEZ:  enc = {6'b000001, bus.rs, 5'b00001, bus.imm};
            OP_BLTZ:  enc = {6'b000001, bus.rs, 5'b00000, bus.imm};
            OP_JAL:   enc = {6'b000011, bus.target};
            default:  legal = 1'b0;
        endcase
    end

    // Words emitted plus the one sitting in the output register; also the index of the next word.
    assign occupancy   = {1'b0, count_q} + (ADDR_W+2)'(out_valid_q);
    assign bus.in_ready = (!out_valid_q || bus.out_ready) && (occupancy < DEPTH_W);

    assign accept = bus.in_valid && bus.in_ready;
    assign retire = out_valid_q && bus.out_ready;
    assign load   = accept && legal;

    always_comb begin
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        illegal_d   = illegal_q | (accept && !legal);
        if (retire) begin
            out_valid_d = 1'b0;
            if (!full) count_d = count_q + (ADDR_W+1)'(1);
        end
        if (load) begin
            out_valid_d = 1'b1;
            out_instr_d = enc;
            out_addr_d  = BASE_ADDR + (32'(occupancy) << 2);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= BASE_ADDR;
            illegal_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_addr  = out_addr_q;
    assign count         = count_q;
    assign full          = (count_q == DEPTH_W[ADDR_W:0]);
    assign illegal       = illegal_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a full-depth instance for encoding and handshakes,
// and a 4-word instance for saturation and clear behaviour.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    always #5 clk = ~clk;

    instr_encoder_if if_m ();
    instr_encoder_if if_s ();
    logic [10:0] cnt_m;
    logic        full_m, ill_m;
    logic [2:0]  cnt_s;
    logic        full_s, ill_s;

    instr_encoder #(.ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_m),
        .count(cnt_m), .full(full_m), .illegal(ill_m)
    );
    instr_encoder #(.ADDR_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_s),
        .count(cnt_s), .full(full_s), .illegal(ill_s)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic set_req(input logic [4:0] o, input logic [4:0] s, input logic [4:0] t,
                           input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg);
        if_m.in_valid = 1'b1; if_m.op = o; if_m.rs = s; if_m.rt = t; if_m.rd = d;
        if_m.imm = im; if_m.target = tg;
    endtask

    task automatic do_clear();
        @(negedge clk);
        if_m.in_valid = 1'b0; if_s.in_valid = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (if_m.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0b exp 0", if_m.out_valid); end
        n_vec++; if (if_m.out_instr !== 32'h0) begin n_err++; $display("FAIL rst_out_instr got %h exp 0", if_m.out_instr); end
        n_vec++; if (if_m.out_addr !== 32'h3000) begin n_err++; $display("FAIL rst_out_addr got %h exp 3000", if_m.out_addr); end
        n_vec++; if (cnt_m !== 11'd0 || full_m !== 1'b0 || ill_m !== 1'b0) begin n_err++; $display("FAIL rst_status got cnt=%0d full=%0b ill=%0b exp 0/0/0", cnt_m, full_m, ill_m); end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (if_m.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %0b exp 1", if_m.in_ready); end
    endtask

    task automatic test_addu();
        if_m.out_ready = 1'b1;
        @(negedge clk);
        set_req(5'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0);
        @(negedge clk);
        if_m.in_valid = 1'b0;
        n_vec++; if (if_m.out_valid !== 1'b1 || if_m.out_instr !== 32'h00221821) begin n_err++; $display("FAIL addu_word got v=%0b %h exp v=1 00221821", if_m.out_valid, if_m.out_instr); end
        n_vec++; if (if_m.out_addr !== 32'h3000) begin n_err++; $display("FAIL addu_addr got %h exp 3000", if_m.out_addr); end
        @(negedge clk);
        n_vec++; if (cnt_m !== 11'd1 || if_m.out_valid !== 1'b0) begin n_err++; $display("FAIL addu_count got cnt=%0d v=%0b exp 1/0", cnt_m, if_m.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  t_op [4];
        logic [4:0]  t_rs [4];
        logic [4:0]  t_rt [4];
        logic [4:0]  t_rd [4];
        logic [15:0] t_im [4];
        logic [25:0] t_tg [4];
        logic [31:0] t_ex [4];
        t_op = '{5'd3, 5'd7, 5'd8, 5'd5};
        t_rs = '{5'd0, 5'd31, 5'd0, 5'd0};
        t_rt = '{5'd1, 5'd7, 5'd0, 5'd8};
        t_rd = '{5'd0, 5'd9, 5'd0, 5'd0};
        t_im = '{16'h1234, 16'h0000, 16'h0000, 16'h0004};
        t_tg = '{26'h0, 26'h0, 26'h0000C00, 26'h0};
        t_ex = '{32'h3C011234, 32'h03E00008, 32'h0C000C00, 32'hAC080004};
        do_clear();
        if_m.out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_vec++; if (if_m.out_valid !== 1'b1 || if_m.out_instr !== t_ex[i-1] || if_m.out_addr !== 32'h3000 + 32'(4*(i-1)))
                    begin n_err++; $display("FAIL b2b_word%0d got v=%0b %h @%h exp %h @%h", i-1, if_m.out_valid, if_m.out_instr, if_m.out_addr, t_ex[i-1], 32'h3000 + 32'(4*(i-1))); end
            end
            if (i < 4) begin
                set_req(t_op[i], t_rs[i], t_rt[i], t_rd[i], t_im[i], t_tg[i]);
                #1;
                n_vec++; if (if_m.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d got %0b exp 1", i, if_m.in_ready); end
            end else begin
                if_m.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_vec++; if (cnt_m !== 11'd4) begin n_err++; $display("FAIL b2b_count got %0d exp 4", cnt_m); end
    endtask

    task automatic test_encodings();
        logic [4:0]  t_op [16];
        logic [4:0]  t_rs [16];
        logic [4:0]  t_rt [16];
        logic [15:0] t_im [16];
        logic [25:0] t_tg [16];
        logic [31:0] t_ex [16];
        t_op = '{5'd0, 5'd1, 5'd14, 5'd17, 5'd2, 5'd4, 5'd6, 5'd13,
                 5'd15, 5'd16, 5'd10, 5'd11, 5'd3, 5'd9, 5'd12, 5'd8};
        t_rs = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd29, 5'd1, 5'd1,
                 5'd1, 5'd1, 5'd3, 5'd3, 5'd5, 5'd5, 5'd5, 5'd31};
        t_rt = '{5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd4, 5'd2, 5'd2,
                 5'd2, 5'd2, 5'd7, 5'd7, 5'd1, 5'd9, 5'd9, 5'd9};
        t_im = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hABCD, 16'h0008, 16'h0008, 16'h0008,
                 16'h0005, 16'h0005, 16'h0010, 16'h0010, 16'h1234, 16'hFFFF, 16'hFFFF, 16'h5555};
        t_tg = '{26'h2AAAAAA, 26'h2AAAAAA, 26'h2AAAAAA, 26'h2AAAAAA, 26'h2AAAAAA, 26'h2AAAAAA, 26'h2AAAAAA, 26'h2AAAAAA,
                 26'h2AAAAAA, 26'h2AAAAAA, 26'h2AAAAAA, 26'h2AAAAAA, 26'h2AAAAAA, 26'h2AAAAAA, 26'h2AAAAAA, 26'h3FFFFFF};
        t_ex = '{32'h00221821, 32'h00221823, 32'h0022182A, 32'h0022182B, 32'h3422ABCD, 32'h8FA40008, 32'h10220008, 32'h14220008,
                 32'h28220005, 32'h2C220005, 32'h1C600010, 32'h18600010, 32'h3C011234, 32'h04A1FFFF, 32'h04A0FFFF, 32'h0FFFFFFF};
        do_clear();
        if_m.out_ready = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_vec++; if (if_m.out_valid !== 1'b1 || if_m.out_instr !== t_ex[i-1] || if_m.out_addr !== 32'h3000 + 32'(4*(i-1)))
                    begin n_err++; $display("FAIL enc_op%0d got v=%0b %h @%h exp %h @%h", t_op[i-1], if_m.out_valid, if_m.out_instr, if_m.out_addr, t_ex[i-1], 32'h3000 + 32'(4*(i-1))); end
            end
            if (i < 16) set_req(t_op[i], t_rs[i], t_rt[i], 5'd3, t_im[i], t_tg[i]);
            else if_m.in_valid = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        do_clear();
        if_m.out_ready = 1'b0;
        @(negedge clk);
        set_req(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        @(negedge clk);
        set_req(5'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++; if (if_m.in_ready !== 1'b0 || if_m.out_valid !== 1'b1 || if_m.out_instr !== 32'h00221821 || if_m.out_addr !== 32'h3000)
                begin n_err++; $display("FAIL bp_hold%0d got rdy=%0b v=%0b %h @%h exp 0/1 00221821 @3000", c, if_m.in_ready, if_m.out_valid, if_m.out_instr, if_m.out_addr); end
            @(negedge clk);
        end
        if_m.out_ready = 1'b1;
        #1;
        n_vec++; if (if_m.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %0b exp 1", if_m.in_ready); end
        @(negedge clk);
        if_m.in_valid = 1'b0;
        n_vec++; if (if_m.out_valid !== 1'b1 || if_m.out_instr !== 32'h00221823 || if_m.out_addr !== 32'h3004 || cnt_m !== 11'd1)
            begin n_err++; $display("FAIL bp_swap got v=%0b %h @%h cnt=%0d exp 1 00221823 @3004 cnt=1", if_m.out_valid, if_m.out_instr, if_m.out_addr, cnt_m); end
        @(negedge clk);
        n_vec++; if (cnt_m !== 11'd2 || if_m.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got cnt=%0d v=%0b exp 2/0", cnt_m, if_m.out_valid); end
    endtask

    task automatic test_illegal();
        do_clear();
        if_m.out_ready = 1'b1;
        @(negedge clk);
        set_req(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        @(negedge clk);
        set_req(5'd25, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        n_vec++; if (if_m.out_addr !== 32'h3000 || ill_m !== 1'b0) begin n_err++; $display("FAIL ill_first got @%h ill=%0b exp @3000 ill=0", if_m.out_addr, ill_m); end
        @(negedge clk);
        set_req(5'd0, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0);
        n_vec++; if (ill_m !== 1'b1 || if_m.out_valid !== 1'b0 || cnt_m !== 11'd1) begin n_err++; $display("FAIL ill_consumed got ill=%0b v=%0b cnt=%0d exp 1/0/1", ill_m, if_m.out_valid, cnt_m); end
        @(negedge clk);
        if_m.in_valid = 1'b0;
        n_vec++; if (if_m.out_valid !== 1'b1 || if_m.out_instr !== 32'h00222021 || if_m.out_addr !== 32'h3004)
            begin n_err++; $display("FAIL ill_second got v=%0b %h @%h exp 1 00222021 @3004", if_m.out_valid, if_m.out_instr, if_m.out_addr); end
        @(negedge clk);
        n_vec++; if (cnt_m !== 11'd2 || ill_m !== 1'b1) begin n_err++; $display("FAIL ill_total got cnt=%0d ill=%0b exp 2/1", cnt_m, ill_m); end
        do_clear();
        n_vec++; if (ill_m !== 1'b0 || cnt_m !== 11'd0) begin n_err++; $display("FAIL ill_clear got ill=%0b cnt=%0d exp 0/0", ill_m, cnt_m); end
    endtask

    task automatic test_full();
        int acc = 0;
        int emitted = 0;
        do_clear();
        if_s.out_ready = 1'b1;
        if_s.op = 5'd0; if_s.rs = 5'd1; if_s.rt = 5'd2; if_s.rd = 5'd3; if_s.imm = 16'h0; if_s.target = 26'h0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (if_s.out_valid === 1'b1) begin
                n_vec++; if (if_s.out_addr !== 32'h3000 + 32'(4*emitted)) begin n_err++; $display("FAIL full_addr%0d got %h exp %h", emitted, if_s.out_addr, 32'h3000 + 32'(4*emitted)); end
                emitted++;
            end
            if_s.in_valid = (acc < 6);
            #1;
            if (if_s.in_valid && if_s.in_ready) acc++;
        end
        n_vec++; if (acc != 4 || emitted != 4) begin n_err++; $display("FAIL full_accepts got acc=%0d emit=%0d exp 4/4", acc, emitted); end
        n_vec++; if (cnt_s !== 3'd4 || full_s !== 1'b1 || if_s.in_ready !== 1'b0) begin n_err++; $display("FAIL full_state got cnt=%0d full=%0b rdy=%0b exp 4/1/0", cnt_s, full_s, if_s.in_ready); end
        do_clear();
        #1;
        n_vec++; if (cnt_s !== 3'd0 || full_s !== 1'b0 || if_s.out_addr !== 32'h3000 || if_s.in_ready !== 1'b1)
            begin n_err++; $display("FAIL full_clear got cnt=%0d full=%0b @%h rdy=%0b exp 0/0 @3000 1", cnt_s, full_s, if_s.out_addr, if_s.in_ready); end
        // A word retiring on the same edge as clear must not be counted.
        @(negedge clk);
        if_s.in_valid = 1'b1;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; if_s.in_valid = 1'b0;
        n_vec++; if (cnt_s !== 3'd0 || if_s.out_valid !== 1'b0 || if_s.out_instr !== 32'h0)
            begin n_err++; $display("FAIL clear_coincident got cnt=%0d v=%0b %h exp 0/0 0", cnt_s, if_s.out_valid, if_s.out_instr); end
        if_s.in_valid = 1'b1;
        @(negedge clk);
        if_s.in_valid = 1'b0;
        n_vec++; if (if_s.out_valid !== 1'b1 || if_s.out_addr !== 32'h3000) begin n_err++; $display("FAIL clear_restart got v=%0b @%h exp 1 @3000", if_s.out_valid, if_s.out_addr); end
    endtask

    initial begin
        clear = 1'b0; rst_n = 1'b0;
        if_m.in_valid = 1'b0; if_m.op = '0; if_m.rs = '0; if_m.rt = '0; if_m.rd = '0;
        if_m.imm = '0; if_m.target = '0; if_m.out_ready = 1'b0;
        if_s.in_valid = 1'b0; if_s.op = '0; if_s.rs = '0; if_s.rt = '0; if_s.rd = '0;
        if_s.imm = '0; if_s.target = '0; if_s.out_ready = 1'b0;
        test_reset();
        test_addu();
        test_back_to_back();
        test_encodings();
        test_backpressure();
        test_illegal();
        test_full();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
